// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the control unit and div_unit.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             div_control;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             div_end;
  logic             div_zero;
  logic             busy;

  modport master (
    output div_control, a_in, b_in,
    input  hi_out, lo_out, div_end, div_zero, busy
  );

  modport slave (
    input  div_control, a_in, b_in,
    output hi_out, lo_out, div_end, div_zero, busy
  );
endinterface

// File: rtl/div_unit.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, then sign fix.
// Quotient goes to LO, remainder to HI; remainder takes the dividend's sign.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE,
    S_ZERO
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_end_nxt;
  logic             w_zero_nxt;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_end;
  logic             r_zero;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // Negating the most negative value wraps back to itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign w_a_mag  = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign w_b_mag  = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;

  assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  assign w_ge     = ~w_diff[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_end_nxt  = 1'b0;
    w_zero_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.div_control) begin
          w_next = (bus.b_in == '0) ? S_ZERO : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        w_end_nxt = 1'b1;
        w_next    = S_IDLE;
      end
      S_ZERO: begin
        w_end_nxt  = 1'b1;
        w_zero_nxt = 1'b1;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dvd    <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_end    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_end  <= w_end_nxt;
      r_zero <= w_zero_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.div_control) begin
            r_sign_q <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
            r_sign_r <= bus.a_in[WIDTH-1];
            r_dvd    <= w_a_mag;
            r_div    <= w_b_mag;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_lo <= r_sign_q ? -r_quo : r_quo;
          r_hi <= r_sign_r ? -r_rem : r_rem;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.hi_out   = r_hi;
  assign bus.lo_out   = r_lo;
  assign bus.div_end  = r_end;
  assign bus.div_zero = r_zero;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, hand-written corner sequences,
// and random operands checked against a plain-arithmetic reference.
module tb_div_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  div_unit_if #(.WIDTH(WIDTH)) bus ();

  div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: signed division in 64-bit arithmetic, truncating toward zero.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, q64, r64;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    q64 = sa / sb;
    r64 = sa - q64 * sb;
    q   = q64[31:0];
    r   = r64[31:0];
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    bus.a_in        = a;
    bus.b_in        = b;
    bus.div_control = 1'b1;
    @(posedge clk);
    #1;
    bus.div_control = 1'b0;
    bus.a_in        = $urandom;
    bus.b_in        = $urandom;
    busy_ok         = (bus.busy === 1'b1);
    lat             = -1;
    for (int k = 1; k <= LAT + 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.div_end === 1'b1) begin
        lat = k;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1 || bus.div_zero !== 1'b0) busy_ok = 1'b0;
    end
  endtask

  task automatic check_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic ezero);
    int   lat;
    logic busy_ok;
    run_op(a, b, lat, busy_ok);
    chk({nm, " latency"}, 32'(lat), ezero ? 32'd1 : 32'(LAT));
    chk({nm, " lo"}, bus.lo_out, elo);
    chk({nm, " hi"}, bus.hi_out, ehi);
    chk({nm, " div_zero"}, {31'd0, bus.div_zero}, {31'd0, ezero});
    chk({nm, " busy"}, {31'd0, busy_ok}, 32'd1);
    @(posedge clk);
    #1;
    chk({nm, " end pulse width"}, {31'd0, bus.div_end}, 32'd0);
  endtask

  vec_t vt[10];

  initial begin
    logic [31:0] q, r, a, b;
    int          lat;
    logic        seen;

    n_vec = 0;
    n_bad = 0;
    vt[0] = '{32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
    vt[1] = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vt[2] = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vt[3] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    vt[4] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vt[5] = '{32'd5,          32'd0,          32'd14,         32'd2,          1'b1};
    vt[6] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vt[7] = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
    vt[8] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vt[9] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};

    reset           = 1'b1;
    bus.div_control = 1'b0;
    bus.a_in        = '0;
    bus.b_in        = '0;
    repeat (2) @(negedge clk);
    chk("reset lo", bus.lo_out, 32'd0);
    chk("reset hi", bus.hi_out, 32'd0);
    chk("reset flags", {29'd0, bus.div_end, bus.div_zero, bus.busy}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      check_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].lo, vt[i].hi, vt[i].zero);
    end
    last_lo = 32'd3;
    last_hi = 32'd0;

    // Second start strobe while busy must be ignored.
    @(negedge clk);
    bus.a_in = 32'd100; bus.b_in = 32'd7; bus.div_control = 1'b1;
    @(posedge clk);
    #1;
    bus.div_control = 1'b0;
    lat = -1;
    for (int k = 1; k <= LAT + 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.div_end === 1'b1) begin
        lat = k;
        break;
      end
      if (k == 9) begin
        bus.a_in = 32'd1; bus.b_in = 32'd1; bus.div_control = 1'b1;
      end else begin
        bus.div_control = 1'b0;
      end
    end
    chk("ignored start latency", 32'(lat), 32'(LAT));
    chk("ignored start lo", bus.lo_out, 32'd14);
    chk("ignored start hi", bus.hi_out, 32'd2);

    // Asynchronous reset mid-division.
    @(negedge clk);
    bus.a_in = 32'd100; bus.b_in = 32'd7; bus.div_control = 1'b1;
    @(posedge clk);
    #1;
    bus.div_control = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async reset lo", bus.lo_out, 32'd0);
    chk("async reset hi", bus.hi_out, 32'd0);
    chk("async reset flags", {29'd0, bus.div_end, bus.div_zero, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < LAT + 6; k++) begin
      @(posedge clk);
      #1;
      if (bus.div_end !== 1'b0) seen = 1'b1;
    end
    chk("no end after reset", {31'd0, seen}, 32'd0);
    check_op("post-reset 9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    last_lo = 32'd3;
    last_hi = 32'd0;

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = ($urandom_range(0, 1) == 1) ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = $urandom; end
        default: b = $urandom;
      endcase
      if (b == 32'd0) begin
        check_op($sformatf("rnd%0d", i), a, b, last_lo, last_hi, 1'b1);
      end else begin
        ref_div(a, b, q, r);
        check_op($sformatf("rnd%0d", i), a, b, q, r, 1'b0);
        last_lo = q;
        last_hi = r;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
